// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: index width, entry type codes,
// the per-entry record and a wrap-around pointer increment.
package reorder_buffer_pkg;

    localparam int ROB_W    = 3;
    localparam int ROB_SIZE = 1 << ROB_W;

    typedef logic [ROB_W-1:0] rob_idx_t;

    typedef enum logic [1:0] {
        ROB_TYPE_REG = 2'd0,
        ROB_TYPE_BR  = 2'd1,
        ROB_TYPE_ST  = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        mispred;
        logic [31:0] target;
    } rob_entry_t;

    function automatic rob_idx_t rob_inc(input rob_idx_t idx);
        return idx + rob_idx_t'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_entry_array.sv
// ROB entry storage: issue/writeback/retire write ports, head read port, two forwarding ports.
// Reads are combinational; writes land at the clock edge, flush clears every busy bit.
module reorder_buffer_entry_array
    import reorder_buffer_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        flush_i,
    input  logic        issue_we_i,
    input  rob_idx_t    issue_idx_i,
    input  rob_type_e   issue_typ_i,
    input  logic [4:0]  issue_rd_i,
    input  logic        wb_we_i,
    input  logic        byp_vld_i,
    input  rob_idx_t    wb_idx_i,
    input  logic [31:0] wb_val_i,
    input  logic        wb_mispred_i,
    input  logic [31:0] wb_target_i,
    input  logic        retire_we_i,
    input  rob_idx_t    retire_idx_i,
    input  rob_idx_t    head_idx_i,
    output rob_entry_t  head_o,
    input  rob_idx_t    q1_idx_i,
    input  rob_idx_t    q2_idx_i,
    output logic        q1_avail_o,
    output logic [31:0] q1_val_o,
    output logic        q2_avail_o,
    output logic [31:0] q2_val_o
);

    rob_entry_t ent_q [ROB_SIZE];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_q[i].busy  <= 1'b0;
                ent_q[i].ready <= 1'b0;
            end
        end else begin
            if (issue_we_i) begin
                ent_q[issue_idx_i].busy    <= 1'b1;
                ent_q[issue_idx_i].ready   <= 1'b0;
                ent_q[issue_idx_i].mispred <= 1'b0;
                ent_q[issue_idx_i].typ     <= issue_typ_i;
                ent_q[issue_idx_i].rd      <= issue_rd_i;
            end
            if (wb_we_i && ent_q[wb_idx_i].busy) begin
                ent_q[wb_idx_i].val     <= wb_val_i;
                ent_q[wb_idx_i].mispred <= wb_mispred_i;
                ent_q[wb_idx_i].target  <= wb_target_i;
                ent_q[wb_idx_i].ready   <= 1'b1;
            end
            // Retire after writeback so a late CDB hit on the head cannot keep it alive.
            if (retire_we_i) begin
                ent_q[retire_idx_i].busy  <= 1'b0;
                ent_q[retire_idx_i].ready <= 1'b0;
            end
        end
    end

    assign head_o = ent_q[head_idx_i];

    // Forwarding prefers the CDB value in flight over the stored one.
    always_comb begin
        q1_avail_o = ent_q[q1_idx_i].busy &&
                     (ent_q[q1_idx_i].ready || (byp_vld_i && wb_idx_i == q1_idx_i));
        q1_val_o   = 32'd0;
        if (ent_q[q1_idx_i].busy) begin
            q1_val_o = (byp_vld_i && wb_idx_i == q1_idx_i) ? wb_val_i : ent_q[q1_idx_i].val;
        end
        q2_avail_o = ent_q[q2_idx_i].busy &&
                     (ent_q[q2_idx_i].ready || (byp_vld_i && wb_idx_i == q2_idx_i));
        q2_val_o   = 32'd0;
        if (ent_q[q2_idx_i].busy) begin
            q2_val_o = (byp_vld_i && wb_idx_i == q2_idx_i) ? wb_val_i : ent_q[q2_idx_i].val;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, capture CDB results, retire one per cycle at head.
// Commit outputs are combinational from registered head state; issue stalls on full or flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             issue_valid,
    input  logic [1:0]       issue_type,
    input  logic [4:0]       issue_rd,
    output logic             issue_ready,
    output logic [ROB_W-1:0] issue_rob_id,
    output logic [4:0]       set_dep_id,
    output logic [ROB_W-1:0] set_dep_Q,
    input  logic             wb_valid,
    input  logic [ROB_W-1:0] wb_rob_id,
    input  logic [31:0]      wb_val,
    input  logic             wb_mispredict,
    input  logic [31:0]      wb_target,
    output logic [4:0]       set_id,
    output logic [31:0]      set_val,
    output logic [ROB_W-1:0] set_from_rob_id,
    output logic             rob_clear,
    output logic [31:0]      clear_pc,
    output logic             store_commit,
    output logic [ROB_W-1:0] store_rob_id,
    input  logic [ROB_W-1:0] get_rob_id_1,
    input  logic [ROB_W-1:0] get_rob_id_2,
    output logic             rob_avail_1,
    output logic [31:0]      rob_val_1,
    output logic             rob_avail_2,
    output logic [31:0]      rob_val_2
);

    localparam logic [ROB_W:0] COUNT_FULL = (ROB_W+1)'(ROB_SIZE);
    localparam logic [ROB_W:0] COUNT_ONE  = {{ROB_W{1'b0}}, 1'b1};

    rob_idx_t       head_q, head_d, tail_q, tail_d;
    logic [ROB_W:0] count_q, count_d;
    rob_entry_t     head_ent;
    logic           full, commit_fire, retire, issue_acc, wb_we;
    rob_type_e      issue_typ;
    logic [4:0]     issue_rd_eff;

    assign full         = (count_q == COUNT_FULL);
    assign issue_typ    = rob_type_e'(issue_type);
    assign issue_rd_eff = (issue_typ == ROB_TYPE_REG) ? issue_rd : 5'd0;
    assign issue_ready  = rdy_in && !full && !rob_clear;
    assign issue_acc    = issue_valid && issue_ready;
    assign issue_rob_id = tail_q;
    assign set_dep_Q    = tail_q;
    assign set_dep_id   = issue_acc ? issue_rd_eff : 5'd0;
    assign retire       = commit_fire && !rob_clear;
    // A flushing cycle discards the CDB result along with everything else.
    assign wb_we        = wb_valid && rdy_in && !rob_clear;

    always_comb begin
        commit_fire     = rdy_in && head_ent.busy && head_ent.ready;
        rob_clear       = 1'b0;
        clear_pc        = 32'd0;
        set_id          = 5'd0;
        set_val         = 32'd0;
        set_from_rob_id = '0;
        store_commit    = 1'b0;
        store_rob_id    = '0;
        if (commit_fire) begin
            set_from_rob_id = head_q;
            case (head_ent.typ)
                ROB_TYPE_REG: begin
                    set_id  = head_ent.rd;
                    set_val = head_ent.val;
                end
                ROB_TYPE_ST: begin
                    store_commit = 1'b1;
                    store_rob_id = head_q;
                end
                ROB_TYPE_BR: begin
                    if (head_ent.mispred) begin
                        rob_clear = 1'b1;
                        clear_pc  = head_ent.target;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rob_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue_acc) tail_d = rob_inc(tail_q);
            if (retire)    head_d = rob_inc(head_q);
            case ({issue_acc, retire})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    reorder_buffer_entry_array u_entries (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .flush_i      (rob_clear),
        .issue_we_i   (issue_acc),
        .issue_idx_i  (tail_q),
        .issue_typ_i  (issue_typ),
        .issue_rd_i   (issue_rd_eff),
        .wb_we_i      (wb_we),
        .byp_vld_i    (wb_valid),
        .wb_idx_i     (wb_rob_id),
        .wb_val_i     (wb_val),
        .wb_mispred_i (wb_mispredict),
        .wb_target_i  (wb_target),
        .retire_we_i  (retire),
        .retire_idx_i (head_q),
        .head_idx_i   (head_q),
        .head_o       (head_ent),
        .q1_idx_i     (get_rob_id_1),
        .q2_idx_i     (get_rob_id_2),
        .q1_avail_o   (rob_avail_1),
        .q1_val_o     (rob_val_1),
        .q2_avail_o   (rob_avail_2),
        .q2_val_o     (rob_val_2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: vector table for issue/forwarding, commit scoreboard, corner sequences.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [2:0]  issue_rob_id, set_dep_Q;
    logic [4:0]  set_dep_id;
    logic        wb_valid, wb_mispredict;
    logic [2:0]  wb_rob_id;
    logic [31:0] wb_val, wb_target;
    logic [4:0]  set_id;
    logic [31:0] set_val, clear_pc;
    logic [2:0]  set_from_rob_id, store_rob_id;
    logic        rob_clear, store_commit;
    logic [2:0]  get_rob_id_1, get_rob_id_2;
    logic        rob_avail_1, rob_avail_2;
    logic [31:0] rob_val_1, rob_val_2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  kind;   // 0 register commit, 1 flush, 2 store
        logic [4:0]  rd;
        logic [2:0]  id;
        logic [31:0] pc;
    } sb_t;
    sb_t sb[$];
    logic [31:0] wbval [8];

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic        wv;
        logic [2:0]  wid;
        logic [31:0] wval;
        logic [2:0]  g1, g2;
        logic        e_rdy;
        logic [2:0]  e_id;
        logic [4:0]  e_dep;
        logic        e_av1, cv1, e_av2, cv2;
        logic [31:0] e_v1, e_v2;
    } vec_t;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_rob_id(issue_rob_id),
        .set_dep_id(set_dep_id), .set_dep_Q(set_dep_Q),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .set_id(set_id), .set_val(set_val), .set_from_rob_id(set_from_rob_id),
        .rob_clear(rob_clear), .clear_pc(clear_pc),
        .store_commit(store_commit), .store_rob_id(store_rob_id),
        .get_rob_id_1(get_rob_id_1), .get_rob_id_2(get_rob_id_2),
        .rob_avail_1(rob_avail_1), .rob_val_1(rob_val_1),
        .rob_avail_2(rob_avail_2), .rob_val_2(rob_val_2)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0;
        wb_valid = 1'b0; wb_rob_id = 3'd0; wb_val = 32'd0;
        wb_mispredict = 1'b0; wb_target = 32'd0;
        get_rob_id_1 = 3'd0; get_rob_id_2 = 3'd0;
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd;
    endtask

    task automatic wb(input logic [2:0] id, input logic [31:0] v, input logic mp, input logic [31:0] tg);
        wb_valid = 1'b1; wb_rob_id = id; wb_val = v; wb_mispredict = mp; wb_target = tg;
        wbval[id] = v;
    endtask

    task automatic push(input logic [1:0] kind, input logic [4:0] rd, input logic [2:0] id, input logic [31:0] pc);
        sb_t e;
        e.kind = kind; e.rd = rd; e.id = id; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0; rdy_in = 1'b1; idle();
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // Commit monitor: every observable retirement must match the oldest expected one.
    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk_in);
            #2;
            if (rst_n_in === 1'b1 && (set_id != 5'd0 || store_commit || rob_clear)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_commit set_id=%0d store=%0b clear=%0b required none",
                             set_id, store_commit, rob_clear);
                end else begin
                    e = sb.pop_front();
                    case (e.kind)
                        2'd0: begin
                            chk("commit_rd", 32'(set_id), 32'(e.rd));
                            chk("commit_val", set_val, wbval[e.id]);
                            chk("commit_from", 32'(set_from_rob_id), 32'(e.id));
                            chk("commit_nostore", 32'(store_commit), 32'h0);
                        end
                        2'd1: begin
                            chk("clear_flag", 32'(rob_clear), 32'h1);
                            chk("clear_pc", clear_pc, e.pc);
                            chk("clear_noreg", 32'(set_id), 32'h0);
                        end
                        default: begin
                            chk("store_flag", 32'(store_commit), 32'h1);
                            chk("store_id", 32'(store_rob_id), 32'(e.id));
                            chk("store_noreg", 32'(set_id), 32'h0);
                        end
                    endcase
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog simulation did not finish, required finish before 50000");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs [9];
        int   order [7] = '{7, 5, 3, 1, 0, 4, 6};
        int   n;

        for (int i = 0; i < 9; i++) begin
            vecs[i].iv = 1'b1; vecs[i].ird = 5'(i + 1);
            vecs[i].wv = 1'b0; vecs[i].wid = 3'd0; vecs[i].wval = 32'd0;
            vecs[i].g1 = 3'(i); vecs[i].g2 = 3'(i);
            vecs[i].e_rdy = (i < 8); vecs[i].e_id = 3'(i);
            vecs[i].e_dep = (i < 8) ? 5'(i + 1) : 5'd0;
            vecs[i].e_av1 = 1'b0; vecs[i].cv1 = 1'b1; vecs[i].e_v1 = 32'd0;
            vecs[i].e_av2 = 1'b0; vecs[i].cv2 = 1'b1; vecs[i].e_v2 = 32'd0;
        end
        vecs[3].wv = 1'b1; vecs[3].wid = 3'd2; vecs[3].wval = 32'd7;
        vecs[3].g1 = 3'd2; vecs[3].e_av1 = 1'b1; vecs[3].e_v1 = 32'd7; vecs[3].g2 = 3'd5;
        vecs[4].g1 = 3'd2; vecs[4].e_av1 = 1'b1; vecs[4].e_v1 = 32'd7;
        vecs[5].wv = 1'b1; vecs[5].wid = 3'd6; vecs[5].wval = 32'd9; vecs[5].g1 = 3'd6;
        vecs[7].g1 = 3'd6; vecs[7].cv1 = 1'b0;
        vecs[8].g1 = 3'd2; vecs[8].e_av1 = 1'b1; vecs[8].e_v1 = 32'd7;
        vecs[8].g2 = 3'd2; vecs[8].e_av2 = 1'b1; vecs[8].e_v2 = 32'd7;

        // Reset state, checked while reset is still asserted.
        rst_n_in = 1'b0; rdy_in = 1'b1; idle();
        #2;
        chk("rst_issue_ready", 32'(issue_ready), 32'h1);
        chk("rst_issue_rob_id", 32'(issue_rob_id), 32'h0);
        chk("rst_set_dep_Q", 32'(set_dep_Q), 32'h0);
        chk("rst_set_id", 32'(set_id), 32'h0);
        chk("rst_set_val", set_val, 32'h0);
        chk("rst_rob_clear", 32'(rob_clear), 32'h0);
        chk("rst_clear_pc", clear_pc, 32'h0);
        chk("rst_store_commit", 32'(store_commit), 32'h0);
        chk("rst_avail1", 32'(rob_avail_1), 32'h0);
        chk("rst_val1", rob_val_1, 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Single REG instruction through issue, writeback and commit.
        issue(2'd0, 5'd5);
        #1;
        chk("t1_issue_rob_id", 32'(issue_rob_id), 32'h0);
        chk("t1_set_dep_id", 32'(set_dep_id), 32'd5);
        chk("t1_set_dep_Q", 32'(set_dep_Q), 32'h0);
        push(2'd0, 5'd5, 3'd0, 32'd0);
        tick();
        idle(); wb(3'd0, 32'hDEADBEEF, 1'b0, 32'd0); get_rob_id_1 = 3'd0;
        #1;
        chk("t1_fwd_avail", 32'(rob_avail_1), 32'h1);
        chk("t1_fwd_val", rob_val_1, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("t1_count_before", 32'(dut.count_q), 32'd1);
        tick();
        chk("t1_count_after", 32'(dut.count_q), 32'd0);

        // Fill to full with forwarding queries along the way; the 9th issue is refused.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            idle();
            issue_valid = vecs[i].iv; issue_type = 2'd0; issue_rd = vecs[i].ird;
            wb_valid = vecs[i].wv; wb_rob_id = vecs[i].wid; wb_val = vecs[i].wval;
            if (vecs[i].wv) wbval[vecs[i].wid] = vecs[i].wval;
            get_rob_id_1 = vecs[i].g1; get_rob_id_2 = vecs[i].g2;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(issue_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_rob_id", i), 32'(issue_rob_id), 32'(vecs[i].e_id));
            chk($sformatf("vec%0d_dep_id", i), 32'(set_dep_id), 32'(vecs[i].e_dep));
            chk($sformatf("vec%0d_avail1", i), 32'(rob_avail_1), 32'(vecs[i].e_av1));
            if (vecs[i].cv1) chk($sformatf("vec%0d_val1", i), rob_val_1, vecs[i].e_v1);
            chk($sformatf("vec%0d_avail2", i), 32'(rob_avail_2), 32'(vecs[i].e_av2));
            if (vecs[i].cv2) chk($sformatf("vec%0d_val2", i), rob_val_2, vecs[i].e_v2);
            if (vecs[i].iv && vecs[i].e_rdy) push(2'd0, vecs[i].ird, vecs[i].e_id, 32'd0);
            tick();
        end
        idle(); wb(3'd0, 32'h11, 1'b0, 32'd0);
        #1;
        chk("full_count", 32'(dut.count_q), 32'd8);
        chk("full_ready", 32'(issue_ready), 32'h0);
        tick();
        idle(); issue(2'd0, 5'd25);
        #1;
        chk("full_commit_ready", 32'(issue_ready), 32'h0);
        chk("full_commit_dep", 32'(set_dep_id), 32'h0);
        tick();
        idle(); issue(2'd0, 5'd20);
        #1;
        chk("wrap_ready", 32'(issue_ready), 32'h1);
        chk("wrap_rob_id", 32'(issue_rob_id), 32'h0);
        chk("wrap_dep_id", 32'(set_dep_id), 32'd20);
        push(2'd0, 5'd20, 3'd0, 32'd0);
        tick();
        for (int k = 0; k < 7; k++) begin
            idle(); wb(3'(order[k]), 32'h100 + 32'(order[k]), 1'b0, 32'd0);
            tick();
        end
        idle();
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick(); n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'h0);
        chk("drain_count", 32'(dut.count_q), 32'd0);

        // Mispredicted branch at head flushes younger entries.
        do_reset();
        issue(2'd1, 5'd7);
        #1; chk("fl_br_id", 32'(issue_rob_id), 32'h0); chk("fl_br_dep", 32'(set_dep_id), 32'h0);
        tick();
        idle(); issue(2'd0, 5'd3);
        #1; chk("fl_reg_id", 32'(issue_rob_id), 32'h1);
        tick();
        idle(); issue(2'd2, 5'd4);
        #1; chk("fl_st_id", 32'(issue_rob_id), 32'h2); chk("fl_st_dep", 32'(set_dep_id), 32'h0);
        tick();
        idle(); wb(3'd1, 32'h33, 1'b0, 32'd0); tick();
        idle(); wb(3'd2, 32'h0, 1'b0, 32'd0); tick();
        idle(); wb(3'd0, 32'h0, 1'b1, 32'h100); tick();
        idle(); push(2'd1, 5'd0, 3'd0, 32'h100);
        issue(2'd0, 5'd9); wb(3'd1, 32'h77, 1'b0, 32'd0);
        #1;
        chk("fl_clear", 32'(rob_clear), 32'h1);
        chk("fl_clear_pc", clear_pc, 32'h100);
        chk("fl_issue_ready", 32'(issue_ready), 32'h0);
        chk("fl_dep_dropped", 32'(set_dep_id), 32'h0);
        tick();
        idle(); issue(2'd1, 5'd0); get_rob_id_1 = 3'd1;
        #1;
        chk("fl_count", 32'(dut.count_q), 32'h0);
        chk("fl_fresh_ready", 32'(issue_ready), 32'h1);
        chk("fl_fresh_id", 32'(issue_rob_id), 32'h0);
        chk("fl_flushed_avail", 32'(rob_avail_1), 32'h0);
        tick();
        idle(); tick();

        // Out-of-order writeback, in-order retirement, store at head.
        do_reset();
        issue(2'd0, 5'd10); push(2'd0, 5'd10, 3'd0, 32'd0); tick();
        idle(); issue(2'd0, 5'd11); push(2'd0, 5'd11, 3'd1, 32'd0); tick();
        idle(); issue(2'd2, 5'd0); push(2'd2, 5'd0, 3'd2, 32'd0); tick();
        idle(); wb(3'd2, 32'hC2, 1'b0, 32'd0); tick();
        idle(); wb(3'd0, 32'hA0, 1'b0, 32'd0); tick();
        idle(); wb(3'd1, 32'hA1, 1'b0, 32'd0); tick();
        idle();
        for (int k = 0; k < 4; k++) tick();
        chk("ooo_drained", 32'(sb.size()), 32'h0);

        // Global enable low freezes a ready head.
        idle(); issue(2'd0, 5'd12);
        #1; chk("rdy_issue_id", 32'(issue_rob_id), 32'd3);
        push(2'd0, 5'd12, 3'd3, 32'd0);
        tick();
        idle(); wb(3'd3, 32'h55, 1'b0, 32'd0); tick();
        idle(); rdy_in = 1'b0;
        #1;
        chk("rdy_set_id", 32'(set_id), 32'h0);
        chk("rdy_set_val", set_val, 32'h0);
        chk("rdy_store", 32'(store_commit), 32'h0);
        chk("rdy_issue_ready", 32'(issue_ready), 32'h0);
        tick();
        idle(); issue(2'd0, 5'd14);
        #1;
        chk("rdy_count_held", 32'(dut.count_q), 32'd1);
        chk("rdy_dep_blocked", 32'(set_dep_id), 32'h0);
        tick();
        idle(); rdy_in = 1'b1; tick();
        idle(); tick();

        // Asynchronous reset in the middle of a commit cycle.
        issue(2'd0, 5'd13);
        #1; chk("ar_issue_id", 32'(issue_rob_id), 32'd4);
        push(2'd0, 5'd13, 3'd4, 32'd0);
        tick();
        idle(); wb(3'd4, 32'h66, 1'b0, 32'd0); tick();
        idle(); get_rob_id_1 = 3'd4;
        #1;
        chk("ar_pre_set_id", 32'(set_id), 32'd13);
        chk("ar_pre_avail", 32'(rob_avail_1), 32'h1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("ar_set_id", 32'(set_id), 32'h0);
        chk("ar_set_val", set_val, 32'h0);
        chk("ar_issue_rob_id", 32'(issue_rob_id), 32'h0);
        chk("ar_avail1", 32'(rob_avail_1), 32'h0);
        chk("ar_val1", rob_val_1, 32'h0);
        chk("ar_count", 32'(dut.count_q), 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer (ROB) for the Tomasulo core.
- Allocates one entry per issued instruction and tells the register file which ROB entry each destination register depends on.
- Captures results from the common data bus (CDB) and answers the register file's operand-forwarding queries.
- Commits at most one instruction per cycle to the register file or the store unit. A mispredicted branch at the head flushes the whole machine.

Parameters:
- ROB_W, 3, index width; ROB_SIZE = 2**ROB_W entries. The shared `ROB_R macro is [ROB_W-1:0].

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  reset; asynchronous, active-low
- rdy_in  in  1  global enable; when low, state frozen and all commit outputs forced to 0
- issue_valid  in  1  allocate an entry this cycle
- issue_type  in  2  entry type: REG=0, BRANCH=1, STORE=2
- issue_rd  in  5  destination register; ignored unless type is REG
- issue_ready  out  1  entry available (!full && !rob_clear)
- issue_rob_id  out  ROB_W  tail index allocated by this issue (combinational)
- set_dep_id  out  5  to regfile: issue_rd when an accepted REG issue has rd!=0, else 0
- set_dep_Q  out  ROB_W  to regfile: equals issue_rob_id
- wb_valid  in  1  CDB result valid
- wb_rob_id  in  ROB_W  CDB target entry
- wb_val  in  32  result value
- wb_mispredict  in  1  branch outcome mismatched prediction
- wb_target  in  32  correct next PC for the branch
- set_id  out  5  commit destination register (0 = no write)
- set_val  out  32  commit value
- set_from_rob_id  out  ROB_W  index of the committing entry (head)
- rob_clear  out  1  flush pulse
- clear_pc  out  32  redirect PC, valid while rob_clear=1
- store_commit  out  1  head STORE retires; the load/store buffer may perform it
- store_rob_id  out  ROB_W  ROB index of the retiring store
- get_rob_id_1, get_rob_id_2  in  ROB_W  regfile operand queries
- rob_avail_1, rob_avail_2  out  1  queried value available
- rob_val_1, rob_val_2  out  32  queried value

Behaviour:
- Per-entry state: busy, ready, type, rd, value, mispredict, target. Pointers: head, tail, count (ROB_W+1 bits).
- Reset (async, rst_n_in low):
  - All busy/ready bits 0; head, tail and count 0.
  - Every output is 0, except issue_ready=1 once rdy_in=1.
- Issue is accepted when issue_valid && issue_ready && rdy_in.
  - At the clock edge, entry[tail] gets busy=1, ready=0, mispredict=0.
  - rd is stored as 0 for non-REG types.
  - tail increments modulo ROB_SIZE.
  - An issue attempted when issue_ready=0 is ignored and has no side effects.
- Writeback: if wb_valid and entry[wb_rob_id] is busy, the entry's value, mispredict and target are latched and ready is set at the edge.
  - Writeback to a non-busy entry is ignored.
- Forwarding (combinational), for each query n:
  - rob_avail_n = busy[q] && (ready[q] || (wb_valid && wb_rob_id==q)).
  - rob_val_n = the CDB value when bypassing, otherwise entry value.
  - A non-busy entry returns avail=0 and val=0.
- Commit fires when head is busy && ready && rdy_in. All commit outputs are combinational from registered head state, so there is one cycle minimum from writeback to commit.
  - REG: set_id=rd, set_val=value, set_from_rob_id=head.
  - STORE: store_commit=1, store_rob_id=head.
  - BRANCH, not mispredicted: retires silently.
  - BRANCH, mispredicted: rob_clear=1, clear_pc=target, no register write.
- Head advance: on a commit without clear, head increments and the entry's busy bit is cleared.
- Count: issue only → +1; commit only → -1; both in the same cycle → unchanged. full = count==ROB_SIZE.
- Flush: on the edge where rob_clear=1, all busy bits clear and head, tail and count go to 0.
  - Any same-cycle issue is dropped; issue_ready is 0 in that cycle.
  - Any same-cycle writeback is dropped.
- Issue, writeback and commit may all target the same cycle. Writeback to the head entry becomes visible to commit on the next cycle.
- Full boundary: when count==ROB_SIZE, a same-cycle commit does not make issue_ready=1; issue_ready is derived from registered count only.
- Wrap-around: head and tail wrap naturally. head==tail with count==0 means empty; with count==ROB_SIZE it means full.

Decomposition:
- const.v holds `ROB_R, the ROB type codes (ROB_TYPE_REG, ROB_TYPE_BR, ROB_TYPE_ST) and ROB_SIZE.
- The entry storage with its two query read ports is a natural sub-module: rob_entry_array (register array, one write port for issue, one for writeback, three read ports for head and the two queries).

Test Plan:
- Reset, then issue REG rd=5 → issue_rob_id=0, set_dep_id=5, set_dep_Q=0. Writeback id 0 with val 0xDEADBEEF; next cycle → set_id=5, set_val=0xDEADBEEF, set_from_rob_id=0; count returns to 0.
- Issue 8 entries → issue_ready=0 and count=8. A 9th issue is ignored. Commit one → issue_ready=1 the following cycle. Issue again → issue_rob_id=0 (wrap-around).
- Query get_rob_id_1=2 while wb_valid, wb_rob_id=2, wb_val=7 → rob_avail_1=1, rob_val_1=7 in the same cycle. A query on a non-busy id → avail=0.
- Issue BRANCH(id 0), REG rd=3 (id 1), STORE (id 2). Writeback all three, branch with mispredict and target 0x100 → rob_clear=1, clear_pc=0x100, set_id=0. Next cycle count=0 and a fresh issue gets id 0.
- Out-of-order writeback order 2, 0, 1 → commits occur strictly in order 0, 1, 2. A STORE head → store_commit=1 with store_rob_id=2.
- Deassert rdy_in with a ready head → no commit outputs asserted and state held. Assert rst_n_in low mid-operation → all outputs 0 immediately, without waiting for a clock edge.
